// File: rtl/instr_load_ctrl_pkg.sv
// Shared types and constants for the instruction-load controller.
// Holds the load FSM state encoding and the instruction word width.
package instr_load_ctrl_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/instr_load_ctrl_if.sv
// Loader / instruction-cache / CPU-control bundle of the instruction-load controller.
// The controller uses the slave modport; the loader/environment side uses master.
interface instr_load_ctrl_if
    import instr_load_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 256
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic               wr_instr_en_i;
    logic [INSTR_W-1:0] wr_instr_i;
    logic               wr_last_i;
    logic               wr_ready_o;
    logic               cache_we_o;
    logic [AW-1:0]      cache_addr_o;
    logic [INSTR_W-1:0] cache_wdata_o;
    logic               cache_ready_i;
    logic               cpu_stall_o;
    logic               cpu_rst_o;
    logic [AW:0]        words_loaded_o;
    logic               overflow_o;

    modport slave (
        input  wr_instr_en_i, wr_instr_i, wr_last_i, cache_ready_i,
        output wr_ready_o, cache_we_o, cache_addr_o, cache_wdata_o,
               cpu_stall_o, cpu_rst_o, words_loaded_o, overflow_o
    );

    modport master (
        output wr_instr_en_i, wr_instr_i, wr_last_i, cache_ready_i,
        input  wr_ready_o, cache_we_o, cache_addr_o, cache_wdata_o,
               cpu_stall_o, cpu_rst_o, words_loaded_o, overflow_o
    );

endinterface

// File: rtl/instr_load_ctrl_sync_fifo.sv
// Single-clock staging FIFO; head is presented combinationally from the storage array.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == (PW+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_load_ctrl.sv
// Streams a loaded program through a staging FIFO into the instruction cache,
// stalling the CPU during the load and pulsing its reset once the load completes.
module instr_load_ctrl
    import instr_load_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    instr_load_ctrl_if.slave  bus
);
    localparam int AW = $clog2(IMEM_WORDS);
    localparam int CW = AW + 1;

    load_state_t        state_r;
    load_state_t        state_s;
    logic [CW-1:0]      count_r;
    logic               overflow_r;
    logic               stall_r;
    logic               cpu_rst_r;

    logic               full_s;
    logic               empty_s;
    logic [INSTR_W-1:0] head_s;
    logic               wr_ready_s;
    logic               accept_s;
    logic               room_s;
    logic               cache_we_s;
    logic               write_s;
    logic               drop_s;
    logic               pop_s;

    // Address and word count are the same counter; it stops at IMEM_WORDS.
    assign room_s     = (count_r < CW'(IMEM_WORDS));
    assign wr_ready_s = ((state_r == IDLE) || (state_r == LOAD)) && !full_s;
    assign accept_s   = bus.wr_instr_en_i && wr_ready_s;
    assign cache_we_s = !empty_s && room_s;
    assign write_s    = cache_we_s && bus.cache_ready_i;
    assign drop_s     = !empty_s && !room_s;
    assign pop_s      = write_s || drop_s;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (accept_s),
        .push_data (bus.wr_instr_i),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Load sequencing: a first word carrying the last flag skips LOAD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = bus.wr_last_i ? DRAIN : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && bus.wr_last_i) begin
                    state_s = DRAIN;
                end else begin
                    state_s = LOAD;
                end
            end
            DRAIN: begin
                if (empty_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counters and registered CPU controls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            count_r    <= '0;
            overflow_r <= 1'b0;
            stall_r    <= 1'b0;
            cpu_rst_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            stall_r   <= (state_s != IDLE);
            cpu_rst_r <= (state_s == DONE);
            // FIFO is always empty in IDLE, so no write can race the clear.
            if (accept_s && (state_r == IDLE)) begin
                count_r    <= '0;
                overflow_r <= 1'b0;
            end else begin
                if (write_s) begin
                    count_r <= count_r + CW'(1);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready_o     = wr_ready_s;
    assign bus.cache_we_o     = cache_we_s;
    assign bus.cache_addr_o   = count_r[AW-1:0];
    assign bus.cache_wdata_o  = head_s;
    assign bus.cpu_stall_o    = stall_r;
    assign bus.cpu_rst_o      = cpu_rst_r;
    assign bus.words_loaded_o = count_r;
    assign bus.overflow_o     = overflow_r;

endmodule

// File: doc/instr_load_ctrl.md
INSTR_LOAD_CTRL -- requirements
Module: instr_load_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 256: instruction-cache depth in 32-bit words; power of two.
REQ-002 Parameter FIFO_DEPTH, default 4: staging FIFO depth in words; power of two, at least 2.
REQ-003 clk_i  input  1  single clock; all state on posedge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 wr_instr_en_i  input  1  program-word valid from the loader.
REQ-006 wr_instr_i  input  32  program word.
REQ-007 wr_last_i  input  1  qualifies the final word of a program; sampled with wr_instr_en_i.
REQ-008 wr_ready_o  output  1  word accepted when wr_instr_en_i && wr_ready_o.
REQ-009 cache_we_o  output  1  instruction-cache write strobe.
REQ-010 cache_addr_o  output  $clog2(IMEM_WORDS)  word address.
REQ-011 cache_wdata_o  output  32  word to write.
REQ-012 cache_ready_i  input  1  cache accepts the write this cycle.
REQ-013 cpu_stall_o  output  1  holds the CPU pipeline while a load is in progress.
REQ-014 cpu_rst_o  output  1  one-cycle pulse restarting the CPU at PC 0 after a load.
REQ-015 words_loaded_o  output  $clog2(IMEM_WORDS)+1  words written in the current or last load.
REQ-016 overflow_o  output  1  sticky flag: the program exceeded IMEM_WORDS.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
- IDLE -> LOAD on the first accepted word.
- LOAD -> DRAIN on an accepted word with wr_last_i=1; a first word with wr_last_i=1 goes IDLE -> DRAIN directly.
- DRAIN -> DONE when the FIFO is empty and no write is pending.
- DONE -> IDLE after exactly one cycle.
REQ-018 wr_ready_o SHALL be 1 only in IDLE or LOAD with the FIFO not full.
- Words presented in DRAIN or DONE are not accepted.
REQ-019 The first accepted word of a load SHALL clear words_loaded_o, the write address and overflow_o.
REQ-020 cache_we_o SHALL be 1 whenever the FIFO is non-empty and the write address is below IMEM_WORDS.
- cache_wdata_o is the FIFO head.
- The write address is held until cache_ready_i=1.
REQ-021 A write with cache_we_o && cache_ready_i SHALL pop the FIFO, increment the address and increment words_loaded_o.
REQ-022 Accepted words in program order SHALL be written to addresses 0,1,2,... with no reordering.
- Minimum latency from accept to cache_we_o is 1 cycle.
REQ-023 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-024 Once IMEM_WORDS words are written, each further FIFO word SHALL be popped with cache_we_o=0 and SHALL set overflow_o.
- The address does not wrap.
- words_loaded_o saturates at IMEM_WORDS.
REQ-025 cpu_stall_o SHALL be 1 in LOAD, DRAIN and DONE, and 0 in IDLE.
REQ-026 cpu_rst_o SHALL be 1 only in the DONE cycle.
REQ-027 All outputs SHALL be registered, except wr_ready_o and cache_we_o, which are decoded from registered state only.

Reset
REQ-028 On rst_i=1 the block SHALL asynchronously clear all state.
- State IDLE; FIFO empty; address, words_loaded_o and overflow_o all 0.
- wr_ready_o=1; cache_we_o, cpu_stall_o and cpu_rst_o all 0.
REQ-029 A reset in the middle of a load SHALL discard all buffered words and SHALL drop cpu_stall_o with no cpu_rst_o pulse.

Structure
REQ-030 A shared package SHALL hold the load_state_t enum (IDLE, LOAD, DRAIN, DONE) and the INSTR_W=32 constant.
REQ-031 The staging buffer SHALL be a separate sub-module, sync_fifo, with push/pop/full/empty ports and parameters DEPTH and WIDTH.

Verification
REQ-032 Load three words (0x00500093, 0x00308113, 0x002081B3), the last with wr_last_i, and cache_ready_i=1:
- Required: writes to addresses 0, 1, 2 in order.
- Required: words_loaded_o=3, a single cpu_rst_o pulse, then cpu_stall_o=0.
REQ-033 Hold cache_ready_i=0 for 10 cycles during a stream of 8 words:
- Required: wr_ready_o drops after 4 accepts.
- Required: cache_addr_o is stable throughout the stall.
- Required: no word is lost or duplicated.
REQ-034 IMEM_WORDS=4 with a 6-word program:
- Required: only addresses 0-3 are written.
- Required: overflow_o=1, words_loaded_o=4, and the FSM still reaches DONE.
REQ-035 Assert rst_i for one cycle in LOAD with 2 words buffered:
- Required: the FIFO empties, there are no further writes, cpu_stall_o=0, and cpu_rst_o never pulses.
REQ-036 Single-word program with wr_last_i=1:
- Required: IDLE -> DRAIN -> DONE -> IDLE, one write to address 0.
- Required: words presented during DRAIN are refused (wr_ready_o=0).
